even_odd_seq_checker: RTL and testbench
=======================================

// Module: even_odd_seq_checker
// PURPOSE
//  Downstream monitor for the 3-bit even/odd counter: samples its count output q and mode input up every clk.
//  - up=1: even sequence 0,2,4,6,0...
//  - up=0: odd sequence 1,3,5,7,1...
//  Checks every step, reports lock, per-step error pulses, a sticky flag and a saturating error count.
//  Sits beside the counter in the datapath; outputs feed status regs/bench scoreboard.
// PARAMETERS
//  W          3  count width of q (sequence wraps mod 2**W)
//  ERR_W      8  width of err_cnt
//  LOCK_CNT   2  consecutive good steps in TRACK before locked=1 (>=1)
//  LOG_DEPTH  4  error-log FIFO entries (ERR_LOG_EN only, power of 2)
// PORTS
//  clk        in   1      single clock, all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      check enable; 0 forces IDLE
//  up         in   1      counter mode, same signal driving the counter
//  q          in   W      counter output
//  clr_err    in   1      clears err_cnt and err_sticky
//  locked     out  1      sequence tracked for >=LOCK_CNT good steps
//  step_err   out  1      1-cycle pulse, mismatch detected
//  err_sticky out  1      set on any step_err, held until clr_err/rst
//  err_cnt    out  ERR_W  saturating mismatch count
//  exp_q      out  W      value expected on q next cycle (valid in TRACK)
//  log_valid  out  1      [ERR_LOG_EN] FIFO non-empty
//  log_data   out  W+1    [ERR_LOG_EN] {up, offending q}
//  log_ready  in   1      [ERR_LOG_EN] pop when log_valid&log_ready
// BEHAVIOUR
//  - Reset: state=IDLE; locked, step_err, err_sticky=0; err_cnt=0; exp_q=0; log FIFO emptied, log_valid=0. Applies mid-operation with same result next cycle.
//  - Parity rule: good parity is q[0]==~up. Expected next value is exp_q=(q_prev+2) mod 2**W, so 6->0 and 7->1 are legal wraps.
//  - FSM:
//    IDLE:  en=1 -> SYNC.
//    SYNC:  if q parity good, capture q, exp_q<=q+2, good_cnt<=0 -> TRACK. Else stay; no error.
//    TRACK: q==exp_q -> exp_q<=q+2, good_cnt++ (saturates at LOCK_CNT); locked=1 once good_cnt==LOCK_CNT.
//           q!=exp_q -> step_err, err_cnt++, locked<=0 -> SYNC.
//  - en=0 in any state -> IDLE next cycle, locked<=0; counters/sticky hold.
//  - Mode change (up != up registered last cycle) in SYNC/TRACK -> SYNC, locked<=0. That cycle is never an error (the counter jumps on a mode switch).
//  - Latency: step_err/err_cnt/locked registered, visible 1 cycle after the q sample.
//  - err_cnt saturates at 2**ERR_W-1; err_sticky stays 1 at saturation.
//  - clr_err with a simultaneous mismatch: err_cnt<=1, err_sticky<=1 (error wins over clear).
//  - step_err never asserts in IDLE or SYNC.
// CONFIGURATION
//  ERR_LOG_EN defined:
//    - each step_err pushes {up,q} into a LOG_DEPTH FIFO with valid/ready pop.
//    - full FIFO drops new entries; err_cnt still counts them.
//    - push and pop in the same cycle are both honoured.
//  ERR_LOG_EN undefined:
//    - log ports, FIFO and log logic absent; all other behaviour identical.
// STRUCTURE
//  - Package eoc_pkg:
//    - typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_TRACK} eoc_state_t
//    - localparam MODE_EVEN=1'b1
//    - function next_exp(q) returning (q+2) mod 2**W
//  - Sub-module eoc_err_log_fifo (sync FIFO, depth LOG_DEPTH, width W+1), instantiated only under ERR_LOG_EN.
// TESTING
//  1. rst=1 3 cycles then release, en=1, up=1, q 0,2,4,6,0,2 -> SYNC->TRACK, locked=1 after 2 good steps, no step_err, 6->0 wrap accepted.
//  2. up=0, q 1,3,5,7,1 -> lock. Inject q=4 where 3 is expected -> step_err 1 cycle later, err_cnt=1, err_sticky=1, locked=0, relock on next good run.
//  3. Locked in even mode, switch up 1->0 while q jumps 4->5 -> no step_err, SYNC then TRACK on odd values, relock.
//  4. ERR_W=2, inject 5 errors -> err_cnt stops at 3. clr_err coincident with 6th error -> err_cnt=1, sticky=1.
//  5. Assert rst mid-TRACK with err_cnt=2 -> next cycle all outputs 0, state IDLE. en=0 mid-TRACK -> locked=0, err_cnt held.
//  6. [ERR_LOG_EN] 5 errors, log_ready=0, depth 4 -> 4 entries {up,q} in order, 5th dropped, err_cnt=5. Then log_ready=1 drains 4 pops.

Source files
------------

// File: rtl/eoc_pkg.sv
// rtl/eoc_pkg.sv - shared types and helpers for the even/odd sequence checker
//
// Contents:
//   eoc_state_t : checker FSM states (IDLE, SYNC, TRACK)
//   MODE_EVEN   : value of 'up' that selects the even sequence
//   next_exp()  : successor of a count value, (q + 2) mod 2**w
package eoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TRACK = 2'd2
    } eoc_state_t;

    localparam logic MODE_EVEN = 1'b1;

    // Callers pass q zero-extended and truncate the result back to w bits.
    function automatic logic [31:0] next_exp(input logic [31:0] q, input int w);
        return (q + 32'd2) & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/eoc_err_log_fifo.sv
// rtl/eoc_err_log_fifo.sv - synchronous FIFO holding logged sequence errors
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset (empties FIFO)
//   push, push_data     : write request and entry; dropped while full unless
//                         a pop happens in the same cycle
//   valid, data, ready  : head entry, popped when valid && ready
// DEPTH must be a power of two, >= 2.
module eoc_err_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    input  logic             ready
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             pop;
    logic             accept;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid  = (wr_ptr != rd_ptr);
    assign pop    = valid && ready;
    assign accept = push && (!full || pop);
    assign data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/even_odd_seq_checker.sv
// rtl/even_odd_seq_checker.sv - monitor for the 3-bit even/odd counter sequence
//
// Optional feature macro: ERR_LOG_EN (adds an error-log FIFO and log ports).
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : check enable, 0 returns the checker to IDLE
//   up         : counter mode (1 = even sequence, 0 = odd sequence)
//   q          : counter output being checked
//   clr_err    : clears err_cnt / err_sticky (a coincident error wins)
//   locked     : LOCK_CNT consecutive good steps seen in TRACK
//   step_err   : one-cycle pulse per mismatch
//   err_sticky : set on any mismatch, held until clr_err / rst
//   err_cnt    : saturating mismatch count
//   exp_q      : value expected on q next cycle (meaningful in TRACK)
//   log_valid, log_data, log_ready : [ERR_LOG_EN] {up, q} of each mismatch
module even_odd_seq_checker
    import eoc_pkg::*;
#(
    parameter int W         = 3,
    parameter int ERR_W     = 8,
    parameter int LOCK_CNT  = 2,
    parameter int LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [W-1:0]     q,
    input  logic             clr_err,
    output logic             locked,
    output logic             step_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [W-1:0]     exp_q
`ifdef ERR_LOG_EN
    ,
    output logic             log_valid,
    output logic [W:0]       log_data,
    input  logic             log_ready
`endif
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam logic [GC_W-1:0] GC_MAX = GC_W'(LOCK_CNT);
    localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_CNT - 1);

    if (LOCK_CNT < 1) begin : g_bad_lock
        $error("LOCK_CNT must be >= 1");
    end
    if (LOG_DEPTH < 2 || (LOG_DEPTH & (LOG_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("LOG_DEPTH must be a power of two >= 2");
    end

    eoc_state_t      state;
    logic            up_q;
    logic [GC_W-1:0] good_cnt;
    logic            mode_chg;
    logic            parity_ok;
    logic            mismatch;
    logic [W-1:0]    q_next;

    // A mode switch makes the counter jump, so it forces a resync instead of
    // being judged against exp_q.
    assign mode_chg  = (up != up_q);
    assign parity_ok = (up == MODE_EVEN) ? !q[0] : q[0];
    assign mismatch  = en && (state == ST_TRACK) && !mode_chg && (q != exp_q);
    assign q_next    = W'(next_exp(32'(q), W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            up_q       <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            exp_q      <= '0;
        end else begin
            up_q     <= up;
            step_err <= mismatch;

            // A mismatch in the same cycle as clr_err still counts once.
            if (mismatch) begin
                err_sticky <= 1'b1;
                if (clr_err)
                    err_cnt <= ERR_W'(1);
                else if (err_cnt != {ERR_W{1'b1}})
                    err_cnt <= err_cnt + ERR_W'(1);
            end else if (clr_err) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end

            if (!en) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_SYNC;
                    ST_SYNC: begin
                        if (!mode_chg && parity_ok) begin
                            exp_q    <= q_next;
                            good_cnt <= '0;
                            state    <= ST_TRACK;
                        end
                    end
                    ST_TRACK: begin
                        if (mode_chg || q != exp_q) begin
                            state  <= ST_SYNC;
                            locked <= 1'b0;
                        end else begin
                            exp_q <= q_next;
                            if (good_cnt != GC_MAX) good_cnt <= good_cnt + 1'b1;
                            // good_cnt is the count before this step
                            if (good_cnt >= GC_LOCK) locked <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ERR_LOG_EN
    eoc_err_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .WIDTH (W + 1)
    ) u_log (
        .clk       (clk),
        .rst       (rst),
        .push      (mismatch),
        .push_data ({up, q}),
        .valid     (log_valid),
        .data      (log_data),
        .ready     (log_ready)
    );
`endif

endmodule

// File: tb/tb_even_odd_seq_checker.sv
// tb/tb_even_odd_seq_checker.sv - directed self-checking bench for even_odd_seq_checker
module tb_even_odd_seq_checker;

    logic       clk = 1'b0;
    logic       rst, en, up, clr_err;
    logic [2:0] q;

    logic       locked, step_err, err_sticky;
    logic [7:0] err_cnt;
    logic [2:0] exp_q;
    logic       locked2, step_err2, err_sticky2;
    logic [1:0] err_cnt2;
    logic [2:0] exp_q2;
`ifdef ERR_LOG_EN
    logic       log_ready;
    logic       log_valid, log_valid2;
    logic [3:0] log_data, log_data2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    even_odd_seq_checker #(.W(3), .ERR_W(8), .LOCK_CNT(2), .LOG_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .q(q), .clr_err(clr_err),
        .locked(locked), .step_err(step_err), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .exp_q(exp_q)
`ifdef ERR_LOG_EN
        , .log_valid(log_valid), .log_data(log_data), .log_ready(log_ready)
`endif
    );

    even_odd_seq_checker #(.W(3), .ERR_W(2), .LOCK_CNT(2), .LOG_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .q(q), .clr_err(clr_err),
        .locked(locked2), .step_err(step_err2), .err_sticky(err_sticky2),
        .err_cnt(err_cnt2), .exp_q(exp_q2)
`ifdef ERR_LOG_EN
        , .log_valid(log_valid2), .log_data(log_data2), .log_ready(log_ready)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Apply q/up for one clock, then sample just after the edge.
    task automatic cyc(input logic [2:0] qv, input logic upv);
        q  = qv;
        up = upv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] errv [5];
        errv = '{3'd2, 3'd4, 3'd6, 3'd0, 3'd5};

        rst = 1'b1; en = 1'b0; up = 1'b1; q = 3'd0; clr_err = 1'b0;
`ifdef ERR_LOG_EN
        log_ready = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_locked",   32'(locked),     0);
        check("rst_step_err", 32'(step_err),   0);
        check("rst_sticky",   32'(err_sticky), 0);
        check("rst_err_cnt",  32'(err_cnt),    0);
        check("rst_exp_q",    32'(exp_q),      0);
`ifdef ERR_LOG_EN
        check("rst_log_valid", 32'(log_valid), 0);
`endif

        // 1: even sequence with 6->0 wrap
        rst = 1'b0; en = 1'b1;
        cyc(0, 1);
        cyc(2, 1);
        cyc(4, 1);
        check("t1_not_yet_locked", 32'(locked), 0);
        cyc(6, 1);
        check("t1_locked",   32'(locked), 1);
        check("t1_exp_wrap", 32'(exp_q),  0);
        check("t1_locked2",  32'(locked2), 1);
        cyc(0, 1);
        check("t1_exp_after_wrap", 32'(exp_q), 2);
        cyc(2, 1);
        check("t1_no_err",  32'(step_err), 0);
        check("t1_locked_hold", 32'(locked), 1);
        check("t1_exp_q2",  32'(exp_q2), 4);
        check("t1_err_cnt", 32'(err_cnt), 0);

        // 2: odd sequence, lock, inject 4 where 3 expected, relock
        cyc(1, 0);
        check("t2_mode_unlock", 32'(locked), 0);
        check("t2_mode_no_err", 32'(step_err), 0);
        cyc(3, 0);
        cyc(5, 0);
        cyc(7, 0);
        check("t2_locked", 32'(locked), 1);
        cyc(1, 0);
        cyc(4, 0);
        check("t2_step_err", 32'(step_err),   1);
        check("t2_err_cnt",  32'(err_cnt),    1);
        check("t2_sticky",   32'(err_sticky), 1);
        check("t2_unlocked", 32'(locked),     0);
        cyc(5, 0);
        check("t2_pulse_end", 32'(step_err), 0);
        cyc(7, 0);
        cyc(1, 0);
        check("t2_relock",   32'(locked), 1);
        check("t2_sticky_hold", 32'(err_sticky), 1);

        // 3: locked even, switch to odd while q jumps 4->5
        cyc(2, 1);
        cyc(4, 1);
        cyc(6, 1);
        cyc(0, 1);
        cyc(2, 1);
        cyc(4, 1);
        check("t3_locked_even", 32'(locked), 1);
        cyc(5, 0);
        check("t3_switch_no_err", 32'(step_err), 0);
        check("t3_switch_unlock", 32'(locked),   0);
        cyc(7, 0);
        cyc(1, 0);
        cyc(3, 0);
        check("t3_relock",  32'(locked),  1);
        check("t3_err_cnt", 32'(err_cnt), 1);

        // 4: clear, five errors (dut2 saturates at 3), sixth error with clr_err
        clr_err = 1'b1;
        cyc(5, 0);
        clr_err = 1'b0;
        check("t4_clr_cnt",    32'(err_cnt),    0);
        check("t4_clr_sticky", 32'(err_sticky), 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0);
            check($sformatf("t4_err%0d_pulse", i), 32'(step_err2), 1);
            cyc(1, 0);
        end
        check("t4_sat_cnt2",  32'(err_cnt2),    3);
        check("t4_cnt8",      32'(err_cnt),     5);
        check("t4_sticky2",   32'(err_sticky2), 1);
        clr_err = 1'b1;
        cyc(0, 0);
        clr_err = 1'b0;
        check("t4_clr_err_cnt2", 32'(err_cnt2),    1);
        check("t4_clr_err_cnt",  32'(err_cnt),     1);
        check("t4_clr_err_stk",  32'(err_sticky),  1);

        // 5: reset mid-TRACK with err_cnt=2, then en=0 mid-TRACK
        cyc(1, 0);
        cyc(0, 0);
        cyc(1, 0);
        cyc(3, 0);
        check("t5_cnt_before_rst", 32'(err_cnt), 2);
        rst = 1'b1;
        cyc(5, 0);
        rst = 1'b0;
        check("t5_rst_locked", 32'(locked),     0);
        check("t5_rst_err",    32'(step_err),   0);
        check("t5_rst_sticky", 32'(err_sticky), 0);
        check("t5_rst_cnt",    32'(err_cnt),    0);
        check("t5_rst_exp",    32'(exp_q),      0);
        cyc(5, 0);
        cyc(7, 0);
        cyc(0, 0);
        check("t5_err_after_rst", 32'(step_err), 1);
        cyc(1, 0);
        cyc(3, 0);
        cyc(5, 0);
        check("t5_locked", 32'(locked), 1);
        en = 1'b0;
        cyc(7, 0);
        check("t5_en_off_unlock", 32'(locked),  0);
        check("t5_en_off_cnt",    32'(err_cnt), 1);
        cyc(0, 0);
        check("t5_idle_no_err",   32'(step_err),   0);
        check("t5_idle_sticky",   32'(err_sticky), 1);

`ifdef ERR_LOG_EN
        // 6: five errors into a depth-4 log with no pops, then drain
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
        check("t6_rst_log_valid", 32'(log_valid), 0);
        en = 1'b1;
        cyc(5, 0);
        cyc(7, 0);
        cyc(1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(errv[i], 0);
            cyc(1, 0);
        end
        check("t6_err_cnt",   32'(err_cnt),   5);
        check("t6_log_valid", 32'(log_valid), 1);
        en = 1'b0;
        log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_log_data%0d", i), 32'(log_data), 32'({1'b0, errv[i]}));
            check($sformatf("t6_log_valid%0d", i), 32'(log_valid), 1);
            @(posedge clk);
            #1;
        end
        check("t6_log_empty", 32'(log_valid), 0);
        log_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
